// File: rtl/catrina_servo_pkg.sv
// Shared types and constants for the catrina servo controller.
package catrina_servo_pkg;
  localparam int NUM_CH = 4;
  localparam int POS_W  = 8;
  localparam int PW_W   = 20;

  localparam logic [1:0] CH_CUELLO = 2'd0;
  localparam logic [1:0] CH_MAND   = 2'd1;
  localparam logic [1:0] CH_OJOSH  = 2'd2;
  localparam logic [1:0] CH_OJOSV  = 2'd3;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [PW_W-1:0]  pw_t;

  localparam pos_t CENTER_POS = 8'd128;
endpackage

// File: rtl/servo_slew_step.sv
// Rate-limited position step: moves cur toward tgt by at most SLEW per frame.
module servo_slew_step
  import catrina_servo_pkg::*;
#(
  parameter int SLEW = 4
) (
  input  pos_t cur,
  input  pos_t tgt,
  input  logic jmp,
  output pos_t cur_new
);
  localparam logic [POS_W:0] SLEW_MAG = (POS_W+1)'(SLEW);
  localparam pos_t           SLEW_POS = POS_W'(SLEW);

  logic signed [POS_W:0] d;
  logic        [POS_W:0] mag;

  always_comb begin
    d       = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag     = d[POS_W] ? $unsigned(-d) : $unsigned(d);
    cur_new = tgt;
    if (!(jmp || SLEW == 0) && (mag > SLEW_MAG))
      cur_new = d[POS_W] ? (cur - SLEW_POS) : (cur + SLEW_POS);
  end
endmodule

// File: rtl/servo_motion_sequencer.sv
// Four-channel hobby-servo PWM generator with per-frame slew-limited targets
// fed by a valid/ready command port.
module servo_motion_sequencer
  import catrina_servo_pkg::*;
#(
  parameter int FRAME_CYC = 1_000_000,
  parameter int MIN_CYC   = 50_000,
  parameter int STEP_CYC  = 196,
  parameter int SLEW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic [7:0] cmd_pos,
  input  logic       cmd_jump,
  output logic [3:0] servo_pwm,
  output logic [3:0] busy,
  output logic       frame_tick
);
  localparam pw_t FRAME_LAST = PW_W'(FRAME_CYC - 1);
  localparam pw_t MIN_W      = PW_W'(MIN_CYC);
  localparam pw_t STEP_W     = PW_W'(STEP_CYC);
  localparam pw_t CENTER_W   = MIN_W + PW_W'(CENTER_POS) * STEP_W;

  pw_t               cnt, cnt_n;
  pos_t              tgt     [NUM_CH];
  pos_t              cur     [NUM_CH];
  pos_t              tgt_n   [NUM_CH];
  pos_t              cur_n   [NUM_CH];
  pos_t              cur_new [NUM_CH];
  pw_t               w       [NUM_CH];
  pw_t               w_n     [NUM_CH];
  logic [NUM_CH-1:0] jmp, jmp_n;
  logic [NUM_CH-1:0] pwm_n, busy_n;
  logic              boundary, accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slew
    servo_slew_step #(.SLEW(SLEW)) u_slew (
      .cur     (cur[i]),
      .tgt     (tgt[i]),
      .jmp     (jmp[i]),
      .cur_new (cur_new[i])
    );
  end

  // Next-state: boundary update takes priority; commands are blocked there by cmd_ready.
  always_comb begin
    boundary = (cnt == FRAME_LAST);
    cnt_n    = boundary ? '0 : cnt + 1'b1;
    accept   = cmd_valid && cmd_ready;
    jmp_n    = jmp;
    pwm_n    = '0;
    busy_n   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_n[i] = tgt[i];
      cur_n[i] = cur[i];
      w_n[i]   = w[i];
      if (boundary) begin
        cur_n[i] = cur_new[i];
        jmp_n[i] = 1'b0;
        w_n[i]   = MIN_W + PW_W'(cur_new[i]) * STEP_W;
      end else if (accept && (cmd_ch == 2'(i))) begin
        tgt_n[i] = cmd_pos;
        jmp_n[i] = cmd_jump;
      end
      pwm_n[i]  = (cnt_n < w_n[i]);
      busy_n[i] = (cur_n[i] != tgt_n[i]) || jmp_n[i];
    end
  end

  // Registered state and outputs; outputs reflect the state they are derived from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= FRAME_LAST;
      jmp        <= '0;
      servo_pwm  <= '0;
      busy       <= '0;
      frame_tick <= 1'b0;
      cmd_ready  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= CENTER_POS;
        cur[i] <= CENTER_POS;
        w[i]   <= CENTER_W;
      end
    end else begin
      cnt        <= cnt_n;
      jmp        <= jmp_n;
      servo_pwm  <= pwm_n;
      busy       <= busy_n;
      frame_tick <= boundary;
      cmd_ready  <= (cnt_n != FRAME_LAST);
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= tgt_n[i];
        cur[i] <= cur_n[i];
        w[i]   <= w_n[i];
      end
    end
  end
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Scoreboard bench: per-frame pulse widths measured on servo_pwm are compared
// against expected widths queued when each command is issued.
module tb_servo_motion_sequencer;
  localparam int FRAME = 1000;

  typedef struct { int w[4]; int len; } frame_t;
  typedef struct { int w[4]; logic [3:0] busy; } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_ch = 2'd0;
  logic [7:0] cmd_pos = 8'd0;
  logic       cmd_jump = 1'b0;
  logic [3:0] servo_pwm, busy;
  logic       frame_tick;

  int     checks = 0;
  int     passes = 0;
  frame_t meas_q[$];
  exp_t   exp_q[$];

  servo_motion_sequencer #(
    .FRAME_CYC(FRAME), .MIN_CYC(50), .STEP_CYC(1), .SLEW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .cmd_jump(cmd_jump),
    .servo_pwm(servo_pwm), .busy(busy), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Frame monitor: counts high cycles per channel between successive frame_ticks.
  initial begin
    bit     have;
    int     acc[4];
    int     len;
    frame_t rec;
    have = 1'b0;
    len  = 0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 1'b0;
      end else begin
        if (frame_tick) begin
          if (have) begin
            for (int i = 0; i < 4; i++) rec.w[i] = acc[i];
            rec.len = len;
            meas_q.push_back(rec);
          end
          have = 1'b1;
          len  = 0;
          for (int i = 0; i < 4; i++) acc[i] = 0;
        end
        if (have) begin
          len++;
          for (int i = 0; i < 4; i++) acc[i] += int'(servo_pwm[i]);
        end
      end
    end
  end

  function automatic exp_t mk_exp(int a, int b, int c, int d, logic [3:0] bz);
    exp_t r;
    r.w[0] = a; r.w[1] = b; r.w[2] = c; r.w[3] = d;
    r.busy = bz;
    return r;
  endfunction

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      checks++;
      $display("FAIL frame_tick_wait: tick=%b after %0d cycles, required 1", frame_tick, n);
    end
  endtask

  task automatic next_frame(output frame_t f, output bit ok);
    int n = 0;
    while (meas_q.size() == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = (meas_q.size() != 0);
    if (ok) f = meas_q.pop_front();
  endtask

  task automatic send_cmd(input logic [1:0] ch, input logic [7:0] pos, input logic jmp);
    int n = 0;
    cmd_ch = ch; cmd_pos = pos; cmd_jump = jmp; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    frame_t f; exp_t e; bit ok;
    repeat (3) @(negedge clk);
    checks++; if (servo_pwm !== 4'b0000) $display("FAIL rst_pwm: got %b required 0000", servo_pwm); else passes++;
    checks++; if (busy !== 4'b0000) $display("FAIL rst_busy: got %b required 0000", busy); else passes++;
    checks++; if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b required 0", frame_tick); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_ready: got %b required 0", cmd_ready); else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (frame_tick !== 1'b1) $display("FAIL first_tick: got %b required 1", frame_tick); else passes++;
    checks++; if (servo_pwm !== 4'b1111) $display("FAIL first_pwm: got %b required 1111", servo_pwm); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL first_ready: got %b required 1", cmd_ready); else passes++;
    exp_q.push_back(mk_exp(178, 178, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(178, 178, 178, 178, 4'b0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); next_frame(f, ok);
      if (!ok) begin checks++; $display("FAIL reset_frame: no frame seen, required one"); end
      else begin
        for (int c = 0; c < 4; c++) begin
          checks++; if (f.w[c] !== e.w[c]) $display("FAIL reset_width ch%0d: got %0d required %0d", c, f.w[c], e.w[c]); else passes++;
        end
        checks++; if (f.len !== FRAME) $display("FAIL reset_period: got %0d required %0d", f.len, FRAME); else passes++;
        checks++; if (busy !== e.busy) $display("FAIL reset_busy: got %b required %b", busy, e.busy); else passes++;
      end
    end
  endtask

  task automatic test_slew();
    frame_t f; exp_t e; bit ok;
    wait_tick(); @(negedge clk); meas_q.delete();
    send_cmd(2'd0, 8'd140, 1'b0);
    checks++; if (busy[0] !== 1'b1) $display("FAIL slew_busy_rise: got %b required 1", busy[0]); else passes++;
    exp_q.push_back(mk_exp(178, 178, 178, 178, 4'b0001));
    exp_q.push_back(mk_exp(182, 178, 178, 178, 4'b0001));
    exp_q.push_back(mk_exp(186, 178, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(190, 178, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(190, 178, 178, 178, 4'b0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); next_frame(f, ok);
      if (!ok) begin checks++; $display("FAIL slew_frame: no frame seen, required one"); end
      else begin
        for (int c = 0; c < 4; c++) begin
          checks++; if (f.w[c] !== e.w[c]) $display("FAIL slew_width ch%0d: got %0d required %0d", c, f.w[c], e.w[c]); else passes++;
        end
        checks++; if (busy !== e.busy) $display("FAIL slew_busy: got %b required %b", busy, e.busy); else passes++;
      end
    end
  endtask

  task automatic test_jump();
    frame_t f; exp_t e; bit ok;
    wait_tick(); @(negedge clk); meas_q.delete();
    send_cmd(2'd1, 8'd0, 1'b1);
    checks++; if (busy[1] !== 1'b1) $display("FAIL jump_busy_rise: got %b required 1", busy[1]); else passes++;
    exp_q.push_back(mk_exp(190, 178, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(190,  50, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(190,  50, 178, 178, 4'b0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); next_frame(f, ok);
      if (!ok) begin checks++; $display("FAIL jump_frame: no frame seen, required one"); end
      else begin
        for (int c = 0; c < 4; c++) begin
          checks++; if (f.w[c] !== e.w[c]) $display("FAIL jump_width ch%0d: got %0d required %0d", c, f.w[c], e.w[c]); else passes++;
        end
        checks++; if (busy !== e.busy) $display("FAIL jump_busy: got %b required %b", busy, e.busy); else passes++;
      end
    end
  endtask

  task automatic test_boundary_collision();
    frame_t f; exp_t e; bit ok;
    wait_tick();
    repeat (FRAME - 1) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL coll_ready_last: got %b required 0", cmd_ready); else passes++;
    checks++; if (frame_tick !== 1'b0) $display("FAIL coll_tick_last: got %b required 0", frame_tick); else passes++;
    cmd_ch = 2'd3; cmd_pos = 8'd200; cmd_jump = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    checks++; if (frame_tick !== 1'b1) $display("FAIL coll_tick: got %b required 1", frame_tick); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL coll_ready: got %b required 1", cmd_ready); else passes++;
    checks++; if (busy[3] !== 1'b0) $display("FAIL coll_not_taken: busy3 got %b required 0", busy[3]); else passes++;
    @(negedge clk);
    cmd_valid = 1'b0;
    meas_q.delete();
    checks++; if (busy[3] !== 1'b1) $display("FAIL coll_taken: busy3 got %b required 1", busy[3]); else passes++;
    exp_q.push_back(mk_exp(190, 50, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(190, 50, 178, 250, 4'b0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); next_frame(f, ok);
      if (!ok) begin checks++; $display("FAIL coll_frame: no frame seen, required one"); end
      else begin
        for (int c = 0; c < 4; c++) begin
          checks++; if (f.w[c] !== e.w[c]) $display("FAIL coll_width ch%0d: got %0d required %0d", c, f.w[c], e.w[c]); else passes++;
        end
        checks++; if (busy !== e.busy) $display("FAIL coll_busy: got %b required %b", busy, e.busy); else passes++;
      end
    end
  endtask

  task automatic test_overwrite();
    frame_t f; exp_t e; bit ok;
    wait_tick(); @(negedge clk); meas_q.delete();
    send_cmd(2'd2, 8'd200, 1'b0);
    repeat (2) @(negedge clk);
    send_cmd(2'd2, 8'd100, 1'b0);
    exp_q.push_back(mk_exp(190, 50, 178, 250, 4'b0100));
    exp_q.push_back(mk_exp(190, 50, 174, 250, 4'b0100));
    exp_q.push_back(mk_exp(190, 50, 170, 250, 4'b0100));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); next_frame(f, ok);
      if (!ok) begin checks++; $display("FAIL ovr_frame: no frame seen, required one"); end
      else begin
        for (int c = 0; c < 4; c++) begin
          checks++; if (f.w[c] !== e.w[c]) $display("FAIL ovr_width ch%0d: got %0d required %0d", c, f.w[c], e.w[c]); else passes++;
        end
        checks++; if (busy !== e.busy) $display("FAIL ovr_busy: got %b required %b", busy, e.busy); else passes++;
      end
    end
  endtask

  task automatic test_async_reset();
    frame_t f; exp_t e; bit ok;
    wait_tick();
    send_cmd(2'd0, 8'd0, 1'b1);
    repeat (99) @(negedge clk);
    checks++; if (servo_pwm !== 4'b1101) $display("FAIL arst_pre_pwm: got %b required 1101", servo_pwm); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (servo_pwm !== 4'b0000) $display("FAIL arst_pwm: got %b required 0000", servo_pwm); else passes++;
    checks++; if (busy !== 4'b0000) $display("FAIL arst_busy: got %b required 0000", busy); else passes++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL arst_ready: got %b required 0", cmd_ready); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    meas_q.delete();
    @(negedge clk);
    checks++; if (servo_pwm !== 4'b1111) $display("FAIL arst_rel_pwm: got %b required 1111", servo_pwm); else passes++;
    checks++; if (frame_tick !== 1'b1) $display("FAIL arst_rel_tick: got %b required 1", frame_tick); else passes++;
    exp_q.push_back(mk_exp(178, 178, 178, 178, 4'b0000));
    exp_q.push_back(mk_exp(178, 178, 178, 178, 4'b0000));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); next_frame(f, ok);
      if (!ok) begin checks++; $display("FAIL arst_frame: no frame seen, required one"); end
      else begin
        for (int c = 0; c < 4; c++) begin
          checks++; if (f.w[c] !== e.w[c]) $display("FAIL arst_width ch%0d: got %0d required %0d", c, f.w[c], e.w[c]); else passes++;
        end
        checks++; if (busy !== e.busy) $display("FAIL arst_busy_after: got %b required %b", busy, e.busy); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_slew();
    test_jump();
    test_boundary_collision();
    test_overwrite();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/servo_motion_sequencer.md
# servo_motion_sequencer

Shared servo controller for the catrina animatronic. It owns the four hobby-servo outputs: neck (cuello), jaw (mandibula), eyes horizontal and eyes vertical. It generates all four PWM signals from one 20 ms frame timebase. Behaviour FSMs issue position commands over a valid/ready port, and the block slews each channel toward its target at a bounded rate per frame so motion is smooth and glitch-free.

## Interface
Parameters:
- FRAME_CYC, 1_000_000: clk cycles per PWM frame (20 ms at 50 MHz).
- MIN_CYC, 50_000: pulse width for position 0 (1 ms).
- STEP_CYC, 196: additional pulse cycles per position unit (position 255 gives about 2 ms).
- SLEW, 4: maximum position change per channel per frame; 0 means unlimited.

Ports:
- clk, in, 1: system clock, 50 MHz.
- rst_n, in, 1: asynchronous, active-low reset.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: command can be accepted this cycle.
- cmd_ch, in, 2: channel index: 0 cuello, 1 mandibula, 2 ojosH, 3 ojosV.
- cmd_pos, in, 8: target position, 0..255.
- cmd_jump, in, 1: 1 applies the target at the next frame boundary with no slew limit.
- servo_pwm, out, 4: PWM outputs, bit = channel.
- busy, out, 4: channel current position differs from its target.
- frame_tick, out, 1: one-cycle pulse in the first cycle of each frame.

## Operation
- **Frame counter** `cnt`:
  - Counts 0..FRAME_CYC-1 and wraps.
  - The edge on which `cnt` goes from FRAME_CYC-1 to 0 is the boundary edge.
- **Per-channel registers:** `tgt[7:0]`, `cur[7:0]`, `jmp`, and the latched pulse width `W[19:0]`.
- **Command accept:** on `cmd_valid && cmd_ready`, write `tgt[cmd_ch] <= cmd_pos` and `jmp[cmd_ch] <= cmd_jump`.
  - The last accepted command before a boundary wins.
  - A later command without jump clears a pending jump.
- **Boundary edge, per channel:**
  - If `jmp` or SLEW==0: `cur <= tgt`.
  - Otherwise compute `d = tgt - cur` as a 9-bit signed value:
    - If |d| ≤ SLEW: `cur <= tgt`.
    - Otherwise: `cur <= cur ± SLEW`.
  - `jmp <= 0`.
  - `W <= MIN_CYC + cur_new*STEP_CYC`. This is unsigned, 20 bits, with no overflow at the defaults.
- **PWM:** `servo_pwm[i]` is high exactly in frame cycles with `cnt < W[i]`, and low for the rest of the frame.
  - `W` changes only at the boundary, so pulses are never truncated or stretched mid-frame.
- **busy[i]:** equals `(cur[i] != tgt[i]) || jmp[i]`, evaluated on registered state.
- **cmd_ready:**
  - Low in the cycle where `cnt == FRAME_CYC-1`, so the boundary update never collides with a write.
  - High in all other cycles after reset.
- **Reset (async, rst_n=0):**
  - `tgt` and `cur` = 128 (CENTER).
  - `W` = MIN_CYC + 128*STEP_CYC.
  - `jmp` = 0.
  - `cnt` = FRAME_CYC-1.
  - All outputs 0: servo_pwm=0, busy=0, frame_tick=0, cmd_ready=0.
- **Reset mid-frame:** the current pulse is aborted immediately, with outputs forced low asynchronously, and all pending commands are lost.

## Timing
- All outputs are registered.
- The first rising edge after rst_n deasserts is a boundary edge:
  - `cnt` = 0, frame_tick = 1, and servo_pwm = 4'b1111 in that cycle.
  - cmd_ready = 1 from that cycle.
- frame_tick is high only in cycles with `cnt == 0`.
- **Command-to-motion latency:**
  - A target accepted in frame k first affects `W` in frame k+1.
  - A full-range move (0→255) at SLEW=4 completes in ceil(255/4) = 64 frames.
- busy rises on the edge after the command is accepted, and falls on the boundary edge where `cur` reaches `tgt`.
- A command held with cmd_valid during the `cnt == FRAME_CYC-1` cycle waits one cycle, then is accepted at `cnt == 0`, taking effect at the following boundary.

## Structure
- **Package `catrina_servo_pkg`:**
  - Channel index constants: CH_CUELLO=0, CH_MAND=1, CH_OJOSH=2, CH_OJOSV=3.
  - CENTER_POS = 8'd128.
  - Position width: 8.
  - Pulse-width counter width: 20.
- **Sub-module `servo_slew_step`:** combinational; inputs `cur`, `tgt`, `jmp`; output `cur_new` using the slew rule above. Instantiated four times.
- The top holds the frame counter, command decode, registers and PWM compare.

## Test plan
Sim parameters: FRAME_CYC=1000, MIN_CYC=50, STEP_CYC=1, SLEW=4.
1. **Reset:** release rst_n → in the first cycle frame_tick=1 and servo_pwm=1111; each pwm stays high for 178 cycles; busy=0; frame_tick repeats every 1000 cycles.
2. **Slew move:** cmd ch0, pos 140, jump=0 → ch0 widths are 182, 186, 190 in frames 1..3, then 190 held; busy[0] falls at the boundary of frame 3.
3. **Jump move:** cmd ch1, pos 0, jump=1 → next frame width is 50; other channels are unchanged at 178.
4. **Boundary collision:** assert cmd_valid at cnt=999 → cmd_ready=0 in that cycle, accepted at cnt=0, effective one frame later.
5. **Overwrite:** two commands to ch2 (200, then 100, no jump) in the same frame → slewing goes toward 100 only; width sequence 174, 170, …
6. **Async reset mid-pulse:** drop rst_n at cnt=100 → servo_pwm goes to 0 immediately; after release, all widths are 178 and pending targets are discarded.
